// File: rtl/imem_loader.sv
// imem_loader: instruction RAM with a byte-stream boot loader in front of the CPU fetch port.
// After RST the loader takes a big-endian word count followed by that many 16-bit words
// (HI byte first) and writes them from address 0 upward. It holds the CPU in reset until the
// load completes, then serves ID = mem[IA] combinationally.
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte
// (S_CHK state, ERR output live). With the macro undefined ERR is tied low.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        CK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  input  logic [15:0] IA,
  output logic [15:0] ID,
  output logic        CPU_RST,
  output logic        DONE,
  output logic        ERR
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  // 17 bits so DEPTH is representable even when ADDR_W is 16.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  localparam logic [2:0] S_CNTH = 3'd0;
  localparam logic [2:0] S_CNTL = 3'd1;
  localparam logic [2:0] S_DATH = 3'd2;
  localparam logic [2:0] S_DATL = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd4;
`endif
  localparam logic [2:0] S_RUN  = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  // State reached once the last word (or an empty header) has been taken.
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_END  = S_CHK;
`else
  localparam logic [2:0] S_END  = S_RUN;
`endif

  logic [15:0] mem [DEPTH];

  logic [2:0]  state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] remain_q, remain_d;
  logic [7:0]  cnt_hi_q, cnt_hi_d;
  logic [7:0]  hi_q, hi_d;
  logic        cpu_rst_q;
  logic        done_q;
  logic        accept;
  logic        ptr_in_range;
  logic        ia_in_range;
  logic        we;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
  logic        err_q;
`endif

  // Loader takes bytes in every loading state; stops for good in S_RUN and S_ERR.
  always_comb begin
    RX_READY = (state_q != S_RUN) && (state_q != S_ERR);
  end

  // Handshake and address range decodes.
  always_comb begin
    accept       = RX_VALID & RX_READY;
    // Words past the end of RAM are consumed but never written (no wrap to 0).
    ptr_in_range = ({1'b0, ptr_q} < DEPTH_W);
    ia_in_range  = ({1'b0, IA} < DEPTH_W);
  end

  // Next-state logic: every transition is gated by an accepted byte.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    cnt_hi_d = cnt_hi_q;
    hi_d     = hi_q;
    we       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk_d    = chk_q;
`endif
    case (state_q)
      S_CNTH: begin
        if (accept) begin
          cnt_hi_d = RX_DATA;
          state_d  = S_CNTL;
        end
      end
      S_CNTL: begin
        if (accept) begin
          remain_d = {cnt_hi_q, RX_DATA};
          ptr_d    = 16'd0;
`ifdef LOADER_CHECKSUM_EN
          chk_d    = 8'h00;
`endif
          if ({cnt_hi_q, RX_DATA} == 16'd0) begin
            state_d = S_END;
          end else begin
            state_d = S_DATH;
          end
        end
      end
      S_DATH: begin
        if (accept) begin
          hi_d    = RX_DATA;
`ifdef LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ RX_DATA;
`endif
          state_d = S_DATL;
        end
      end
      S_DATL: begin
        if (accept) begin
          we       = ptr_in_range;
          ptr_d    = ptr_q + 16'd1;
          remain_d = remain_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
          chk_d    = chk_q ^ RX_DATA;
`endif
          if (remain_q == 16'd1) begin
            state_d = S_END;
          end else begin
            state_d = S_DATH;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (RX_DATA == chk_q) begin
            state_d = S_RUN;
          end else begin
            state_d = S_ERR;
          end
        end
      end
`endif
      S_RUN: state_d = S_RUN;
      S_ERR: state_d = S_ERR;
      default: state_d = S_CNTH;
    endcase
  end

  // Loader state registers; CPU_RST/DONE flip on the same edge that enters S_RUN.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q   <= S_CNTH;
      ptr_q     <= 16'd0;
      remain_q  <= 16'd0;
      cnt_hi_q  <= 8'h00;
      hi_q      <= 8'h00;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      remain_q  <= remain_d;
      cnt_hi_q  <= cnt_hi_d;
      hi_q      <= hi_d;
      cpu_rst_q <= (state_d != S_RUN);
      done_q    <= (state_d == S_RUN);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of payload bytes and the sticky error flag.
  always_ff @(posedge CK) begin
    if (RST) begin
      chk_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      chk_q <= chk_d;
      err_q <= (state_d == S_ERR);
    end
  end

  // Error output from its register.
  always_comb begin
    ERR = err_q;
  end
`else
  // No checksum in this build, so the load can never fail.
  always_comb begin
    ERR = 1'b0;
  end
`endif

  // RAM write port; contents survive RST so unloaded words keep old data.
  always_ff @(posedge CK) begin
    if (we && !RST) begin
      mem[ptr_q[ADDR_W-1:0]] <= {hi_q, RX_DATA};
    end
  end

  // Fetch port is asynchronous; a same-cycle write shows up only after the edge.
  always_comb begin
    if (ia_in_range) begin
      ID = mem[IA[ADDR_W-1:0]];
    end else begin
      ID = 16'h0000;
    end
  end

  // Registered CPU control outputs.
  always_comb begin
    CPU_RST = cpu_rst_q;
    DONE    = done_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader. Two instances share every input: dut_a (ADDR_W=8) and
// dut_b (ADDR_W=2, used for the overflow case). Stimulus pushes expectations into a queue;
// a monitor drains it on each falling edge. Define LOADER_CHECKSUM_EN to test that build.
module tb_imem_loader;

  logic        ck;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] ia;

  logic        a_ready, a_cpu_rst, a_done, a_err;
  logic [15:0] a_id;
  logic        b_ready, b_cpu_rst, b_done, b_err;
  logic [15:0] b_id;

  imem_loader #(.ADDR_W(8)) dut_a (
    .CK(ck), .RST(rst), .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(a_ready),
    .IA(ia), .ID(a_id), .CPU_RST(a_cpu_rst), .DONE(a_done), .ERR(a_err)
  );

  imem_loader #(.ADDR_W(2)) dut_b (
    .CK(ck), .RST(rst), .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(b_ready),
    .IA(ia), .ID(b_id), .CPU_RST(b_cpu_rst), .DONE(b_done), .ERR(b_err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  localparam int P_ID_A = 0, P_ID_B = 1;
  localparam int P_DONE_A = 2, P_CRST_A = 3, P_ERR_A = 4, P_RDY_A = 5;
  localparam int P_DONE_B = 6, P_CRST_B = 7, P_ERR_B = 8, P_RDY_B = 9;

  typedef struct {
    int          sig;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  stream[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic logic [15:0] probe(int s);
    case (s)
      P_ID_A:   return a_id;
      P_ID_B:   return b_id;
      P_DONE_A: return {15'b0, a_done};
      P_CRST_A: return {15'b0, a_cpu_rst};
      P_ERR_A:  return {15'b0, a_err};
      P_RDY_A:  return {15'b0, a_ready};
      P_DONE_B: return {15'b0, b_done};
      P_CRST_B: return {15'b0, b_cpu_rst};
      P_ERR_B:  return {15'b0, b_err};
      P_RDY_B:  return {15'b0, b_ready};
      default:  return 16'hxxxx;
    endcase
  endfunction

  task automatic push(input int s, input logic [15:0] e, input string n);
    exp_t t;
    t.sig  = s;
    t.exp  = e;
    t.name = n;
    sb.push_back(t);
  endtask

  // Expected status of both instances, checked at the next falling edge.
  task automatic expect_status(input string tag, input logic d, input logic cr,
                               input logic er, input logic rd);
    push(P_DONE_A, {15'b0, d},  {tag, " done_a"});
    push(P_CRST_A, {15'b0, cr}, {tag, " cpu_rst_a"});
    push(P_ERR_A,  {15'b0, er}, {tag, " err_a"});
    push(P_RDY_A,  {15'b0, rd}, {tag, " ready_a"});
    push(P_DONE_B, {15'b0, d},  {tag, " done_b"});
    push(P_CRST_B, {15'b0, cr}, {tag, " cpu_rst_b"});
    push(P_ERR_B,  {15'b0, er}, {tag, " err_b"});
    push(P_RDY_B,  {15'b0, rd}, {tag, " ready_b"});
  endtask

  task automatic check_id(input int s, input logic [15:0] addr, input logic [15:0] e,
                          input string n);
    ia = addr;
    push(s, e, n);
    @(posedge ck); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge ck); #1;
    @(posedge ck); #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!a_ready && n < 20) begin
      @(posedge ck); #1;
      n++;
    end
    if (n >= 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_byte timeout: ready stayed %b, required 1", a_ready);
    end
    @(posedge ck); #1;
    rx_valid = 1'b0;
    if (gap) begin
      @(posedge ck); #1;
    end
  endtask

  // XOR of the payload bytes (everything after the two header bytes).
  function automatic logic [7:0] xsum();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < stream.size(); i++) x = x ^ stream[i];
    return x;
  endfunction

  function automatic void add_chk();
`ifdef LOADER_CHECKSUM_EN
    stream.push_back(xsum());
`endif
  endfunction

  // Sends the global stream; status just before the final byte must still be "loading".
  task automatic send_stream(input string tag, input bit gap);
    for (int i = 0; i < stream.size(); i++) begin
      if (i == stream.size() - 1) expect_status({tag, " pre-last"}, 1'b0, 1'b1, 1'b0, 1'b1);
      send_byte(stream[i], gap);
    end
  endtask

  // Scoreboard monitor plus the DONE/CPU_RST edge relation.
  initial begin
    exp_t       e;
    logic [15:0] act;
    logic       prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge ck);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = probe(e.sig);
        n_chk++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, required %h", e.name, act, e.exp);
        end
      end
      if (a_done !== prev_done) begin
        n_chk++;
        if (a_cpu_rst !== ~a_done) begin
          n_fail++;
          $display("FAIL done_edge: cpu_rst %b with done %b, required %b", a_cpu_rst, a_done,
                   ~a_done);
        end
      end
      prev_done = a_done;
    end
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    ia       = 16'h0000;
    do_reset();
    expect_status("reset", 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge ck); #1;

    // Basic load.
    stream = {8'h00, 8'h02, 8'hC1, 8'h05, 8'hC2, 8'h07};
    add_chk();
    send_stream("t1", 1'b0);
    expect_status("t1 run", 1'b1, 1'b0, 1'b0, 1'b0);
    check_id(P_ID_A, 16'h0000, 16'hC105, "t1 mem0_a");
    check_id(P_ID_A, 16'h0001, 16'hC207, "t1 mem1_a");
    check_id(P_ID_B, 16'h0001, 16'hC207, "t1 mem1_b");

    // Clear the two words, then reload them with gaps between bytes.
    do_reset();
    stream = {8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    add_chk();
    send_stream("t2 clear", 1'b0);
    check_id(P_ID_A, 16'h0000, 16'h0000, "t2 cleared0_a");
    do_reset();
    stream = {8'h00, 8'h02, 8'hC1, 8'h05, 8'hC2, 8'h07};
    add_chk();
    send_stream("t2", 1'b1);
    expect_status("t2 run", 1'b1, 1'b0, 1'b0, 1'b0);
    check_id(P_ID_A, 16'h0000, 16'hC105, "t2 mem0_a");
    check_id(P_ID_A, 16'h0001, 16'hC207, "t2 mem1_a");
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    repeat (4) begin
      @(posedge ck); #1;
    end
    rx_valid = 1'b0;
    expect_status("t2 extra", 1'b1, 1'b0, 1'b0, 1'b0);
    check_id(P_ID_A, 16'h0000, 16'hC105, "t2 extra mem0_a");
    check_id(P_ID_A, 16'h0001, 16'hC207, "t2 extra mem1_a");

    // Zero-length load.
    do_reset();
    stream = {8'h00, 8'h00};
    add_chk();
    send_stream("t3", 1'b0);
    expect_status("t3 run", 1'b1, 1'b0, 1'b0, 1'b0);
    check_id(P_ID_A, 16'h0000, 16'hC105, "t3 old0_a");
    check_id(P_ID_A, 16'h0001, 16'hC207, "t3 old1_a");

    // Reset in the middle of a load, then a fresh one-word load.
    do_reset();
    stream = {8'h00, 8'h03, 8'h12};
    for (int i = 0; i < stream.size(); i++) send_byte(stream[i], 1'b0);
    expect_status("t4 mid", 1'b0, 1'b1, 1'b0, 1'b1);
    do_reset();
    expect_status("t4 rst", 1'b0, 1'b1, 1'b0, 1'b1);
    stream = {8'h00, 8'h01, 8'hAB, 8'hCD};
    for (int i = 0; i < 3; i++) send_byte(stream[i], 1'b0);
    ia       = 16'h0000;
    rx_data  = 8'hCD;
    rx_valid = 1'b1;
    push(P_ID_A, 16'hC105, "t4 old before write");
    expect_status("t4 pre-word", 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge ck); #1;
    rx_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    expect_status("t4 pre-chk", 1'b0, 1'b1, 1'b0, 1'b1);
    send_byte(xsum(), 1'b0);
`endif
    expect_status("t4 run", 1'b1, 1'b0, 1'b0, 1'b0);
    check_id(P_ID_A, 16'h0000, 16'hABCD, "t4 mem0_a");
    check_id(P_ID_A, 16'h0001, 16'hC207, "t4 mem1_a");

    // More words than dut_b can hold.
    do_reset();
    stream = {8'h00, 8'h05};
    for (int w = 1; w <= 5; w++) begin
      stream.push_back(8'h00);
      stream.push_back(8'(w));
    end
    add_chk();
    send_stream("t5", 1'b0);
    expect_status("t5 run", 1'b1, 1'b0, 1'b0, 1'b0);
    check_id(P_ID_B, 16'h0000, 16'h0001, "t5 mem0_b");
    check_id(P_ID_B, 16'h0001, 16'h0002, "t5 mem1_b");
    check_id(P_ID_B, 16'h0002, 16'h0003, "t5 mem2_b");
    check_id(P_ID_B, 16'h0003, 16'h0004, "t5 mem3_b");
    check_id(P_ID_B, 16'h0004, 16'h0000, "t5 oob4_b");
    check_id(P_ID_B, 16'hFFFF, 16'h0000, "t5 oobffff_b");
    check_id(P_ID_A, 16'h0004, 16'h0005, "t5 mem4_a");
    check_id(P_ID_A, 16'h0100, 16'h0000, "t5 oob100_a");

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum, then the correct one.
    do_reset();
    stream = {8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    send_stream("t6 bad", 1'b0);
    expect_status("t6 err", 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge ck); #1;
    expect_status("t6 err hold", 1'b0, 1'b1, 1'b1, 1'b0);
    do_reset();
    expect_status("t6 rst", 1'b0, 1'b1, 1'b0, 1'b1);
    stream = {8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    send_stream("t6 good", 1'b0);
    expect_status("t6 run", 1'b1, 1'b0, 1'b0, 1'b0);
    check_id(P_ID_A, 16'h0000, 16'h1234, "t6 mem0_a");
`endif

    repeat (3) begin
      @(posedge ck); #1;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
